specdrum_sd_dac: RTL and testbench
==================================

// Module: specdrum_sd_dac
// PURPOSE
//  Stereo output stage directly downstream of the SpecDrum/Covox/Soundrive port latch.
//  Consumes its two 9-bit unsigned channel sums (0..510).
//  Per channel: samples on a strobe, applies volume and soft mute, slew-limits the level
//  to prevent clicks, then drives a first-order delta-sigma 1-bit DAC for the FPGA audio pins.
// PARAMETERS
//  STEP      1   max change of the internal level per clk (slew limit, 1..255)
//  IN_W      9   width of in_left/in_right (fixed by upstream; only 9 is supported)
// PORTS
//  clk          in   1  system clock
//  rst          in   1  synchronous reset, active-high
//  sample_tick  in   1  one-clk strobe; capture inputs
//  in_left      in   9  unsigned left sum from port latch
//  in_right     in   9  unsigned right sum from port latch
//  volume       in   2  0=>>3, 1=>>2, 2=>>1, 3=unity
//  mute         in   1  soft mute request, level-sensitive
//  dac_left     out  1  delta-sigma bitstream, left
//  dac_right    out  1  delta-sigma bitstream, right
//  muted        out  1  high while mute=1 and both levels are 0
// BEHAVIOUR
//  - Clocking: one clock (clk). Reset is synchronous, active-high (rst).
//  - Reset values: hold regs, target, level, acc = 0; dac_left = dac_right = 0; muted = 0.
//  - Capture: sample_tick high at edge N loads hold_l/hold_r <= in_left/in_right.
//    Without sample_tick, hold regs keep their value.
//  - Target (combinational per channel): mute ? 0 : hold >> (3 - volume).
//    volume and mute apply on the next clk; they do not wait for sample_tick.
//  - Slew, 9-bit level per channel, every clk:
//    - level < target: level <= min(level + STEP, target)
//    - level > target: level <= max(level - STEP, target)
//    - otherwise hold. No overshoot; compare before the add so there is no wrap.
//  - Modulator: {carry, acc[8:0]} = acc + level (10-bit sum); acc <= sum[8:0];
//    dac_x <= carry (registered).
//    - Pulse density = level/512; level 0 gives a constant 0.
//  - Latency: input captured at edge N -> target valid after N -> level starts moving at
//    edge N+1 -> first modulated bit at N+2.
//  - muted <= mute & (level_l == 0) & (level_r == 0), registered.
//  - Simultaneous sample_tick and mute: the hold regs still capture, target is 0.
//    On unmute, the level ramps to the captured value.
//  - Inputs above 510 (only 511 is possible): the path handles them without saturation
//    logic; no overflow, since the 9-bit level fits the 10-bit sum.
//  - rst mid-ramp: level and acc clear immediately; the outputs are 0 on the next clk.
// CONFIGURATION
//  SPECDRUM_DITHER_EN defined:
//    - 16-bit Fibonacci LFSR, taps 16,14,13,11, seed 16'hACE1 on rst, advances every clk.
//    - Sum becomes acc + level + lfsr[1:0] (left) / lfsr[3:2] (right), to break idle tones.
//    - A level of 0 while muted forces dac_x = 0 regardless of dither.
//  SPECDRUM_DITHER_EN undefined:
//    - No LFSR; the modulator is fully deterministic as above.
// TESTING
//  1 Reset: rst=1 for 3 clk with in_left=300, sample_tick=1
//    -> dac_left=dac_right=0, muted=0, levels 0.
//  2 Half scale: in_left=256, vol=3, STEP=1, one tick
//    -> level_l reaches 256 after 256 clk; then dac_left alternates 0/1, exactly 256 ones per 512 clk.
//  3 Full scale: in_right=510, vol=3, STEP=8
//    -> level reaches 510 within 64 clk; steady state gives 510 ones per 512 clk on dac_right.
//  4 Volume: in_left=400, vol=1 -> target 100; switch vol=3 without a tick
//    -> level slews to 400 starting next clk.
//  5 Soft mute: level 200, STEP=1, assert mute
//    -> level 0 after 200 clk; muted=1 on the following clk; dac outputs 0.
//    Deassert mute -> ramps back to 200.
//  6 rst asserted mid-ramp (level 120 -> 300)
//    -> next clk level 0, dac 0; after release, ramps from 0 toward held target 0.
//    Rerun 2 with SPECDRUM_DITHER_EN: average density 0.5 +/- 1% over 4096 clk.

Source files
------------

// File: rtl/specdrum_sd_dac.sv
// Stereo output stage for the SpecDrum/Covox/Soundrive latch: volume, soft mute, slew limit, 1-bit delta-sigma DAC.
// Optional build macro SPECDRUM_DITHER_EN adds LFSR dither to both modulators.
module specdrum_sd_dac #(
   parameter int unsigned STEP = 1,
   parameter int unsigned IN_W = 9
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            sample_tick,
   input  logic [IN_W-1:0] in_left,
   input  logic [IN_W-1:0] in_right,
   input  logic [1:0]      volume,
   input  logic            mute,
   output logic            dac_left,
   output logic            dac_right,
   output logic            muted
);

   localparam logic [IN_W-1:0] STEP_V = IN_W'(STEP);

   logic [IN_W-1:0] hold_l, hold_r;
   logic [IN_W-1:0] target_l, target_r;
   logic [IN_W-1:0] level_l, level_r;
   logic [IN_W-1:0] level_l_nxt, level_r_nxt;
   logic [IN_W-1:0] acc_l, acc_r;
   logic [IN_W+1:0] sum_l, sum_r;
   logic [1:0]      shamt;
   logic [1:0]      dith_l, dith_r;
   logic            carry_l, carry_r;
   logic            force_l, force_r;

   // Move lvl toward tgt by at most STEP; the gap is taken before any add so nothing wraps.
   function automatic logic [IN_W-1:0] slew(input logic [IN_W-1:0] lvl,
                                            input logic [IN_W-1:0] tgt);
      logic [IN_W-1:0] gap;
      gap = (lvl < tgt) ? tgt - lvl : lvl - tgt;
      if (gap <= STEP_V) return tgt;
      return (lvl < tgt) ? lvl + STEP_V : lvl - STEP_V;
   endfunction

   assign shamt    = 2'd3 - volume;
   assign target_l = mute ? '0 : hold_l >> shamt;
   assign target_r = mute ? '0 : hold_r >> shamt;

   assign level_l_nxt = slew(level_l, target_l);
   assign level_r_nxt = slew(level_r, target_r);

`ifdef SPECDRUM_DITHER_EN
   logic [15:0] lfsr;

   always_ff @(posedge clk) begin
      if (rst) lfsr <= 16'hACE1;
      else     lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
   end

   assign dith_l  = lfsr[1:0];
   assign dith_r  = lfsr[3:2];
   assign force_l = mute & (level_l == '0);
   assign force_r = mute & (level_r == '0);
`else
   assign dith_l  = 2'd0;
   assign dith_r  = 2'd0;
   assign force_l = 1'b0;
   assign force_r = 1'b0;
`endif

   // Two extra bits keep the dithered sum exact; without dither the top bit is always 0.
   assign sum_l   = (IN_W+2)'(acc_l) + (IN_W+2)'(level_l) + (IN_W+2)'(dith_l);
   assign sum_r   = (IN_W+2)'(acc_r) + (IN_W+2)'(level_r) + (IN_W+2)'(dith_r);
   assign carry_l = |sum_l[IN_W+1:IN_W];
   assign carry_r = |sum_r[IN_W+1:IN_W];

   // NOTE: every register here uses <= so each one samples the pre-edge value of the others.
   always_ff @(posedge clk) begin
      if (rst) begin
         hold_l    <= '0;
         hold_r    <= '0;
         level_l   <= '0;
         level_r   <= '0;
         acc_l     <= '0;
         acc_r     <= '0;
         dac_left  <= 1'b0;
         dac_right <= 1'b0;
         muted     <= 1'b0;
      end else begin
         if (sample_tick) begin
            hold_l <= in_left;
            hold_r <= in_right;
         end
         level_l   <= level_l_nxt;
         level_r   <= level_r_nxt;
         acc_l     <= sum_l[IN_W-1:0];
         acc_r     <= sum_r[IN_W-1:0];
         dac_left  <= carry_l & ~force_l;
         dac_right <= carry_r & ~force_r;
         muted     <= mute & (level_l == '0) & (level_r == '0);
      end
   end

endmodule

// File: tb/tb_specdrum_sd_dac.sv
// Directed bench for specdrum_sd_dac: one STEP=1 instance and one STEP=8 instance on shared inputs.
module tb_specdrum_sd_dac;

   logic       clk;
   logic       rst;
   logic       sample_tick;
   logic [8:0] in_left, in_right;
   logic [1:0] volume;
   logic       mute;
   logic       dac_l1, dac_r1, muted1;
   logic       dac_l8, dac_r8, muted8;

   int n_vec = 0;
   int n_err = 0;
   int ones_l, ones_r, ones_r8, reps_l;

   specdrum_sd_dac #(.STEP(1), .IN_W(9)) dut (
      .clk(clk), .rst(rst), .sample_tick(sample_tick),
      .in_left(in_left), .in_right(in_right), .volume(volume), .mute(mute),
      .dac_left(dac_l1), .dac_right(dac_r1), .muted(muted1)
   );

   specdrum_sd_dac #(.STEP(8), .IN_W(9)) dut8 (
      .clk(clk), .rst(rst), .sample_tick(sample_tick),
      .in_left(in_left), .in_right(in_right), .volume(volume), .mute(mute),
      .dac_left(dac_l8), .dac_right(dac_r8), .muted(muted8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic clk_n(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic tick(input int l, input int r);
      in_left     = 9'(l);
      in_right    = 9'(r);
      sample_tick = 1'b1;
      clk_n(1);
      sample_tick = 1'b0;
   endtask

   // Counts ones on the monitored bitstreams, and repeated consecutive values on dac_l1.
   task automatic count_bits(input int n, output int c_l, output int c_r, output int c_r8,
                             output int rep);
      logic prev;
      c_l = 0; c_r = 0; c_r8 = 0; rep = 0;
      prev = dac_l1;
      for (int i = 0; i < n; i++) begin
         clk_n(1);
         c_l  += int'(dac_l1);
         c_r  += int'(dac_r1);
         c_r8 += int'(dac_r8);
         if (dac_l1 == prev) rep++;
         prev = dac_l1;
      end
   endtask

   initial begin
      rst = 1'b1; sample_tick = 1'b1; in_left = 9'd300; in_right = 9'd0;
      volume = 2'd3; mute = 1'b0;

      // Reset holds everything at zero even with a tick present
      clk_n(3);
      check("rst_dac_l", int'(dac_l1), 0);
      check("rst_dac_r", int'(dac_r1), 0);
      check("rst_muted", int'(muted1), 0);
      check("rst_lvl_l", int'(dut.level_l), 0);
      check("rst_lvl_r", int'(dut.level_r), 0);
      rst = 1'b0; sample_tick = 1'b0;

      // Half scale, STEP=1
      tick(256, 0);
      check("half_lvl_at_capture", int'(dut.level_l), 0);
      clk_n(1);
      check("half_lvl_first_step", int'(dut.level_l), 1);
      clk_n(254);
      check("half_lvl_255", int'(dut.level_l), 255);
      clk_n(1);
      check("half_lvl_256", int'(dut.level_l), 256);
      clk_n(1);
      count_bits(512, ones_l, ones_r, ones_r8, reps_l);
      check("half_ones_l", ones_l, 256);
      check("half_alternate", reps_l, 0);
      check("zero_ones_r", ones_r, 0);
      check("half_lvl_hold", int'(dut.level_l), 256);

      // Full scale on the STEP=8 instance
      tick(256, 510);
      clk_n(63);
      check("full8_lvl_63", int'(dut8.level_r), 504);
      clk_n(1);
      check("full8_lvl_64", int'(dut8.level_r), 510);
      clk_n(1);
      count_bits(512, ones_l, ones_r, ones_r8, reps_l);
      check("full8_ones_r", ones_r8, 510);
      check("full8_no_overshoot", int'(dut8.level_r), 510);

      // Volume: 400 >> 2 = 100, then unity without a tick
      volume = 2'd1;
      tick(400, 510);
      check("vol_lvl_down_first", int'(dut.level_l), 255);
      clk_n(200);
      check("vol1_lvl", int'(dut.level_l), 100);
      volume = 2'd3;
      check("vol3_not_yet", int'(dut.level_l), 100);
      clk_n(1);
      check("vol3_next_clk", int'(dut.level_l), 101);
      clk_n(298);
      check("vol3_lvl_399", int'(dut.level_l), 399);
      clk_n(1);
      check("vol3_lvl_400", int'(dut.level_l), 400);
      clk_n(1);
      check("vol3_lvl_stays", int'(dut.level_l), 400);

      // Soft mute from 200
      tick(200, 200);
      clk_n(600);
      check("mute_pre_lvl_l", int'(dut.level_l), 200);
      check("mute_pre_lvl_r", int'(dut.level_r), 200);
      mute = 1'b1;
      clk_n(199);
      check("mute_lvl_1", int'(dut.level_l), 1);
      check("mute_not_yet", int'(muted1), 0);
      clk_n(1);
      check("mute_lvl_0_l", int'(dut.level_l), 0);
      check("mute_lvl_0_r", int'(dut.level_r), 0);
      check("mute_flag_lags", int'(muted1), 0);
      clk_n(1);
      check("mute_flag", int'(muted1), 1);
      check("mute_dac_l", int'(dac_l1), 0);
      check("mute_dac_r", int'(dac_r1), 0);
      count_bits(16, ones_l, ones_r, ones_r8, reps_l);
      check("mute_silent_l", ones_l, 0);
      check("mute_silent_r", ones_r, 0);

      // Capture while muted, then unmute
      tick(300, 200);
      clk_n(4);
      check("mute_tick_lvl", int'(dut.level_l), 0);
      check("mute_tick_flag", int'(muted1), 1);
      mute = 1'b0;
      clk_n(1);
      check("unmute_flag", int'(muted1), 0);
      check("unmute_lvl_l", int'(dut.level_l), 1);
      clk_n(199);
      check("unmute_lvl_r_200", int'(dut.level_r), 200);
      clk_n(100);
      check("unmute_lvl_l_300", int'(dut.level_l), 300);
      check("unmute_lvl_r_hold", int'(dut.level_r), 200);

      // Reset mid-ramp 120 -> 300
      tick(120, 200);
      clk_n(190);
      check("ramp_lvl_120", int'(dut.level_l), 120);
      tick(300, 200);
      clk_n(50);
      check("ramp_lvl_170", int'(dut.level_l), 170);
      rst = 1'b1;
      clk_n(1);
      check("midrst_lvl_l", int'(dut.level_l), 0);
      check("midrst_lvl_r", int'(dut.level_r), 0);
      check("midrst_dac_l", int'(dac_l1), 0);
      check("midrst_dac_r", int'(dac_r1), 0);
      rst = 1'b0;
      clk_n(10);
      check("postrst_lvl_l", int'(dut.level_l), 0);
      count_bits(20, ones_l, ones_r, ones_r8, reps_l);
      check("postrst_silent_l", ones_l, 0);
      check("postrst_silent_r", ones_r, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
